// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter sharing one registered even-parity checker among NREQ requesters.
// Optional per-requester saturating error counters are enabled with PARITY_ARB_ERR_CNT_EN.
module parity_check_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                en,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [4*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_parity,
  output logic [NREQ-1:0]     req_ready,
  output logic                resp_valid,
  output logic [IDW-1:0]      resp_id,
  output logic                resp_error,
  output logic                err_irq,
  input  logic                err_clr,
  input  logic [IDW-1:0]      cnt_sel,
  output logic [CNT_W-1:0]    cnt_rd_data
);

  logic [IDW-1:0] last;
  logic [IDW-1:0] grant_idx;
  logic           grant_err;
  logic           xfer;
  logic           err_event;

  // Search starts one past the most recent grant, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx       = 0;
    req_ready = '0;
    grant_idx = '0;
    grant_err = 1'b0;
    xfer      = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = int'(last) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!xfer && en && req_valid[idx]) begin
        xfer           = 1'b1;
        req_ready[idx] = 1'b1;
        grant_idx      = IDW'(idx);
        grant_err      = req_parity[idx] ^ (^req_data[4*idx +: 4]);
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      last       <= IDW'(NREQ - 1);
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_error <= 1'b0;
    end else begin
      resp_valid <= xfer;
      if (xfer) begin
        last       <= grant_idx;
        resp_id    <= grant_idx;
        resp_error <= grant_err;
      end
    end
  end

  assign err_event = resp_valid && resp_error;

  // A new error takes precedence over a simultaneous clear.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)          err_irq <= 1'b0;
    else if (err_event) err_irq <= 1'b1;
    else if (err_clr)   err_irq <= 1'b0;
  end

`ifdef PARITY_ARB_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt [NREQ];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NREQ; i++) err_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (err_event && resp_id == IDW'(i)) begin
          if (err_clr)                err_cnt[i] <= CNT_W'(1);
          else if (err_cnt[i] != '1)  err_cnt[i] <= err_cnt[i] + CNT_W'(1);
        end else if (err_clr) begin
          err_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    cnt_rd_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (cnt_sel == IDW'(i)) cnt_rd_data = err_cnt[i];
  end
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_rd_data    = '0;
`endif

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Directed bench for parity_check_arbiter (NREQ=4, CNT_W=8): vector table plus corner sequences.
module tb_parity_check_arbiter;
  logic        clk;
  logic        rstN;
  logic        en;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_parity;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic        resp_error;
  logic        err_irq;
  logic        err_clr;
  logic [1:0]  cnt_sel;
  logic [7:0]  cnt_rd_data;

  int checks = 0;
  int errors = 0;

`ifdef PARITY_ARB_ERR_CNT_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  parity_check_arbiter #(.NREQ(4), .CNT_W(8)) dut (
    .clk(clk), .rstN(rstN), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_parity(req_parity), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_error(resp_error), .err_irq(err_irq), .err_clr(err_clr),
    .cnt_sel(cnt_sel), .cnt_rd_data(cnt_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  v;
    logic [15:0] d;
    logic [3:0]  p;
    logic [3:0]  rdy;
    logic        rv;
    logic [1:0]  rid;
    logic        rerr;
    logic        irq;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_cnt(input logic [1:0] sel, input logic [7:0] exp_when_en, input string name);
    cnt_sel = sel;
    #1;
    chk(name, {24'h0, cnt_rd_data}, HAS_CNT ? {24'h0, exp_when_en} : 32'h0);
  endtask

  initial begin
    //         en  valid    data      parity   ready    rv   id    err  irq
    tbl[0]  = '{1'b1, 4'b1111, 16'h0000, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'b1111, 16'h0000, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'b1111, 16'h0000, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'b1111, 16'h0000, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'b1111, 16'h0000, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'b1111, 16'h0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'b1010, 16'h0000, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'b1010, 16'h0000, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 4'b1010, 16'h0000, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 4'b1010, 16'h0000, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0};
    // Requester 2 nibble 1011: parity 1 is even overall, parity 0 is an error.
    tbl[11] = '{1'b1, 4'b0100, 16'h1B70, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'b0100, 16'h1B70, 4'b0010, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1};

    rstN = 1'b0; en = 1'b0; req_valid = '0; req_data = '0; req_parity = '0;
    err_clr = 1'b0; cnt_sel = '0;
    repeat (3) step();
    chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("reset_resp_id", {30'h0, resp_id}, 32'h0);
    chk("reset_err_irq", {31'h0, err_irq}, 32'h0);
    chk("reset_ready", {28'h0, req_ready}, 32'h0);
    chk("reset_cnt0", {24'h0, cnt_rd_data}, 32'h0);
    rstN = 1'b1;

    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en; req_valid = tbl[i].v; req_data = tbl[i].d; req_parity = tbl[i].p;
      #1;
      chk($sformatf("vec%0d_ready", i), {28'h0, req_ready}, {28'h0, tbl[i].rdy});
      step();
      chk($sformatf("vec%0d_resp_valid", i), {31'h0, resp_valid}, {31'h0, tbl[i].rv});
      if (tbl[i].rv) begin
        chk($sformatf("vec%0d_resp_id", i), {30'h0, resp_id}, {30'h0, tbl[i].rid});
        chk($sformatf("vec%0d_resp_error", i), {31'h0, resp_error}, {31'h0, tbl[i].rerr});
      end
      chk($sformatf("vec%0d_err_irq", i), {31'h0, err_irq}, {31'h0, tbl[i].irq});
    end
    read_cnt(2'd2, 8'd1, "table_cnt2");

    // Clear, then err_clr coincides with an erroring response for requester 1.
    en = 1'b1; req_valid = '0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_err_irq", {31'h0, err_irq}, 32'h0);
    read_cnt(2'd2, 8'd0, "clr_cnt2");
    req_valid = 4'b0001; req_data = 16'h0001; req_parity = 4'b0000;
    #1;
    chk("clr_seq_ready0", {28'h0, req_ready}, 32'h1);
    step();
    req_valid = 4'b0010; req_data = 16'h0010; req_parity = 4'b0000;
    #1;
    chk("clr_seq_ready1", {28'h0, req_ready}, 32'h2);
    step();
    req_valid = '0; err_clr = 1'b1;
    chk("clr_seq_resp_id", {30'h0, resp_id}, 32'h1);
    chk("clr_seq_resp_error", {31'h0, resp_error}, 32'h1);
    read_cnt(2'd0, 8'd1, "pre_clr_cnt0");
    step();
    err_clr = 1'b0;
    chk("clr_vs_err_irq", {31'h0, err_irq}, 32'h1);
    read_cnt(2'd1, 8'd1, "clr_vs_err_cnt1");
    read_cnt(2'd0, 8'd0, "clr_vs_err_cnt0");
    read_cnt(2'd3, 8'd0, "clr_vs_err_cnt3");

    // 300 back-to-back errors from requester 0 saturate its counter.
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    req_valid = 4'b0001; req_data = 16'h0001; req_parity = 4'b0000;
    repeat (300) step();
    req_valid = '0;
    repeat (2) step();
    read_cnt(2'd0, 8'd255, "sat_cnt0");
    chk("sat_err_irq", {31'h0, err_irq}, 32'h1);

    // Reset right after a grant discards the in-flight response.
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    req_valid = 4'b1111; req_data = 16'h0000; req_parity = 4'b0000;
    #1;
    chk("rst_seq_ready", {28'h0, req_ready}, 32'h2);
    step();
    rstN = 1'b0;
    #1;
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_id", {30'h0, resp_id}, 32'h0);
    #1;
    rstN = 1'b1;
    #1;
    chk("post_rst_ready", {28'h0, req_ready}, 32'h1);
    step();
    chk("post_rst_resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("post_rst_resp_id", {30'h0, resp_id}, 32'h0);
    read_cnt(2'd0, 8'd0, "post_rst_cnt0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
